// File: rtl/fifo_bidi_port_ctrl.sv
// Stream-to-FIFO port controller driving a shared bidirectional FIFO data bus.
// One write holding register feeds back-to-back PUSH cycles; reads take POP then CAPT.
module fifo_bidi_port_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  inout  wire [DATA_WIDTH-1:0]  data_bi,
  output logic                  push,
  output logic                  pop,
  input  logic                  full,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [LW-1:0]         level,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  // Handshakes: a word moves on any rising edge where valid && ready are both 1;
  // valid may not depend on ready, and payload is held while valid && !ready.

  typedef enum logic [1:0] {IDLE = 2'd0, PUSH = 2'd1, POP = 2'd2, CAPT = 2'd3} state_t;

  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] wbuf;
  logic                  wbuf_valid, wbuf_valid_nx;
  logic                  rd_valid_nx;
  logic [LW-1:0]         level_nx;
  logic                  last_op_pop;
  logic                  wr_fire, push_cand, pop_cand;

  assign wr_ready  = !wbuf_valid || (state == PUSH);
  assign wr_fire   = wr_valid && wr_ready;
  assign data_bi   = push ? wbuf : {DATA_WIDTH{1'bz}};
  assign state_dbg = state;

  // Everything below looks at the state as it will be right after this edge.
  always_comb begin
    wbuf_valid_nx = wr_fire || (wbuf_valid && (state != PUSH));
    rd_valid_nx   = (state == CAPT) || (rd_valid && !rd_ready);
    level_nx      = level;
    if (state == PUSH && level != DEPTH_L)
      level_nx = level + 1'b1;
    else if (state == POP && level != '0)
      level_nx = level - 1'b1;
    push_cand = wbuf_valid_nx && (level_nx < DEPTH_L);
    pop_cand  = !rd_valid_nx && (level_nx != '0);
    state_nx  = IDLE;
    if (state == POP)
      state_nx = CAPT;
    else if (push_cand && pop_cand)
      state_nx = last_op_pop ? PUSH : POP;
    else if (push_cand)
      state_nx = PUSH;
    else if (pop_cand)
      state_nx = POP;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      push        <= 1'b0;
      pop         <= 1'b0;
      wbuf        <= '0;
      wbuf_valid  <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      level       <= '0;
      err         <= 1'b0;
      last_op_pop <= 1'b1;
    end else begin
      state      <= state_nx;
      push       <= (state_nx == PUSH);
      pop        <= (state_nx == POP);
      wbuf_valid <= wbuf_valid_nx;
      rd_valid   <= rd_valid_nx;
      level      <= level_nx;
      if (wr_fire)
        wbuf <= wr_data;
      if (state == CAPT)
        rd_data <= data_bi;
      if (state != POP && (state_nx == PUSH || state_nx == POP))
        last_op_pop <= (state_nx == POP);
      // Sticky: strobing a full/empty FIFO, or an idle FIFO that disagrees with our count.
      if ((push && full) || (pop && empty) || (state == IDLE && level == '0 && !empty))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_bidi_port_ctrl.sv
// Bench for fifo_bidi_port_ctrl: behavioural bidirectional FIFO, vector table,
// directed multi-cycle sequences and an in-order read scoreboard.
module tb_fifo_bidi_port_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  wire  [7:0] data_bi;
  logic       push, pop, full, empty;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] level;
  logic       err;
  logic [1:0] state_dbg;

  fifo_bidi_port_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset), .data_bi(data_bi), .push(push), .pop(pop),
    .full(full), .empty(empty), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .level(level), .err(err), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Attached FIFO model: stores on push, drives the bus in the cycle after pop.
  logic [7:0] fifo_mem[$];
  int         fifo_cnt = 0;
  logic       fifo_drive = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       force_full = 1'b0;
  logic       force_nonempty = 1'b0;

  assign data_bi = fifo_drive ? fifo_dout : 8'bz;
  assign full    = (fifo_cnt >= 16) || force_full;
  assign empty   = (fifo_cnt == 0) && !force_nonempty;

  always @(posedge clock) begin
    if (reset) begin
      fifo_mem.delete();
      fifo_cnt   <= 0;
      fifo_drive <= 1'b0;
      fifo_dout  <= 8'h00;
    end else begin
      if (push) fifo_mem.push_back(data_bi);
      fifo_drive <= pop;
      if (pop) begin
        if (fifo_mem.size() > 0) fifo_dout <= fifo_mem.pop_front();
        else                     fifo_dout <= 8'hee;
      end
      fifo_cnt <= fifo_mem.size();
    end
  end

  int         pass_cnt = 0;
  int         check_cnt = 0;
  logic [7:0] exp_q[$];
  logic       wr_acc;
  int         cur_run = 0;
  int         max_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    check_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  // Record the handshakes the coming edge will take, advance one cycle, then
  // run the per-cycle monitors away from the edge.
  task automatic tick();
    wr_acc = 1'b0;
    if (reset) begin
      exp_q.delete();
    end else begin
      wr_acc = wr_valid && wr_ready;
      if (wr_acc) exp_q.push_back(wr_data);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) check("rd_unexpected_word", {24'h0, rd_data}, 32'hffff_ffff);
        else check("rd_data_order", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
    @(posedge clock);
    @(negedge clock);
    if (!push && !fifo_drive)
      check("bus_released", {31'h0, (data_bi === 8'bz) || (data_bi === 8'h00)}, 32'd1);
    if (pop)  check("pop_with_level_zero", {31'h0, level != 5'd0}, 32'd1);
    if (push) check("push_with_level_full", {31'h0, level < 5'd16}, 32'd1);
    cur_run = push ? cur_run + 1 : 0;
    if (cur_run > max_run) max_run = cur_run;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    force_full = 1'b0;
    force_nonempty = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       rd_ready;
    logic [1:0] exp_state;
    logic       exp_push;
    logic       exp_pop;
    logic [4:0] exp_level;
    logic       exp_wr_ready;
    logic       exp_rd_valid;
    logic [7:0] exp_rd_data;
  } vec_t;

  vec_t vt[9];
  logic [1:0] cont_seq[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [7:0] held;

    // Two words, one read with a backpressure-free handshake, one left pending.
    vt[0] = '{1'b1, 8'ha1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00};
    vt[1] = '{1'b1, 8'hb2, 1'b0, 2'd1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00};
    vt[2] = '{1'b0, 8'h00, 1'b0, 2'd2, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 8'h00};
    vt[3] = '{1'b0, 8'h00, 1'b0, 2'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
    vt[4] = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 8'ha1};
    vt[5] = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'ha1};
    vt[6] = '{1'b0, 8'h00, 1'b0, 2'd2, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 8'ha1};
    vt[7] = '{1'b0, 8'h00, 1'b0, 2'd3, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'ha1};
    vt[8] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'hb2};
    cont_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("vec%0d_state", i),    {30'h0, state_dbg}, {30'h0, vt[i].exp_state});
      check($sformatf("vec%0d_push", i),     {31'h0, push},      {31'h0, vt[i].exp_push});
      check($sformatf("vec%0d_pop", i),      {31'h0, pop},       {31'h0, vt[i].exp_pop});
      check($sformatf("vec%0d_level", i),    {27'h0, level},     {27'h0, vt[i].exp_level});
      check($sformatf("vec%0d_wr_ready", i), {31'h0, wr_ready},  {31'h0, vt[i].exp_wr_ready});
      check($sformatf("vec%0d_rd_valid", i), {31'h0, rd_valid},  {31'h0, vt[i].exp_rd_valid});
      check($sformatf("vec%0d_rd_data", i),  {24'h0, rd_data},   {24'h0, vt[i].exp_rd_data});
      check($sformatf("vec%0d_err", i),      {31'h0, err},       32'd0);
      wr_valid = vt[i].wr_valid;
      wr_data  = vt[i].wr_data;
      rd_ready = vt[i].rd_ready;
      tick();
    end

    // Fill with reads blocked: one word lands in rd_data, then 16 straight pushes.
    do_reset();
    cnt = 0;
    max_run = 0;
    for (int c = 0; c < 40; c++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(cnt + 1);
      tick();
      if (wr_acc) cnt++;
    end
    check("fill_words_accepted", cnt, 32'd18);
    check("fill_level", {27'h0, level}, 32'd16);
    check("fill_wr_ready", {31'h0, wr_ready}, 32'd0);
    check("fill_push_run", max_run, 32'd16);
    check("fill_rd_valid", {31'h0, rd_valid}, 32'd1);
    check("fill_rd_data", {24'h0, rd_data}, 32'h01);
    check("fill_err", {31'h0, err}, 32'd0);

    // Drain everything in write order.
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
    check("drain_complete", exp_q.size(), 32'd0);
    check("drain_level", {27'h0, level}, 32'd0);
    check("drain_err", {31'h0, err}, 32'd0);

    // Contention: writes and reads always available, grants must alternate.
    do_reset();
    cnt = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("contend_state%0d", i), {30'h0, state_dbg}, {30'h0, cont_seq[i]});
      wr_valid = 1'b1;
      wr_data  = 8'(8'h40 + cnt);
      tick();
      if (wr_acc) cnt++;
    end
    wr_valid = 1'b0;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) tick();
    check("contend_drain_complete", exp_q.size(), 32'd0);

    // Backpressure: pending read word blocks further pops and stays stable.
    do_reset();
    cnt = 0;
    rd_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      wr_valid = (cnt < 3);
      wr_data  = 8'(8'h31 + cnt);
      tick();
      if (wr_acc) cnt++;
    end
    wr_valid = 1'b0;
    check("bp_level", {27'h0, level}, 32'd2);
    check("bp_rd_valid", {31'h0, rd_valid}, 32'd1);
    held = rd_data;
    check("bp_first_word", {24'h0, held}, 32'h31);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_no_pop", {31'h0, pop}, 32'd0);
      check("bp_rd_data_stable", {24'h0, rd_data}, {24'h0, held});
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("bp_pop_after_handshake", {31'h0, pop}, 32'd1);
    tick();
    check("bp_in_capt", {30'h0, state_dbg}, 32'd3);

    // Reset while in CAPT abandons the capture.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_capt_rd_valid", {31'h0, rd_valid}, 32'd0);
    check("rst_capt_level", {27'h0, level}, 32'd0);
    check("rst_capt_state", {30'h0, state_dbg}, 32'd0);
    check("rst_capt_push_pop", {30'h0, push, pop}, 32'd0);
    check("rst_capt_wr_ready", {31'h0, wr_ready}, 32'd1);
    check("rst_capt_rd_data", {24'h0, rd_data}, 32'd0);

    // Fault injection: full during a push, then a non-empty FIFO at level 0.
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    tick();
    wr_valid = 1'b0;
    check("fault_push_cycle", {31'h0, push}, 32'd1);
    force_full = 1'b1;
    tick();
    force_full = 1'b0;
    check("fault_full_err", {31'h0, err}, 32'd1);
    for (int c = 0; c < 3; c++) tick();
    check("fault_err_sticky", {31'h0, err}, 32'd1);
    do_reset();
    check("fault_err_cleared", {31'h0, err}, 32'd0);
    force_nonempty = 1'b1;
    tick();
    force_nonempty = 1'b0;
    check("fault_level_mismatch_err", {31'h0, err}, 32'd1);
    do_reset();
    check("final_err_cleared", {31'h0, err}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
